// File: rtl/serial_console_bridge_pkg.sv
// Shared definitions for the serial console bridge: UART framing constants
// and the transmit FSM state encoding.
package serial_console_bridge_pkg;

  localparam int   UART_DATA_BITS = 8;
  localparam logic LINE_IDLE      = 1'b1;
  localparam logic LINE_START     = 1'b0;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/serial_console_bridge_sync_fifo.sv
// sync_fifo: single-clock FIFO with show-ahead head output.
//   clk_i, rst_ni     clock, async active-low reset (empties the FIFO)
//   push_i, data_i    write strobe and data; ignored while full
//   pop_i             read strobe; ignored while empty
//   data_o            current head entry, 0 while empty
//   full_o, empty_o   status decoded from the occupancy count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only observable once counted in.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/serial_console_bridge.sv
// serial_console_bridge: peripheral end of the processor serial IO port.
// Processor writes are buffered and sent as 8N1 UART frames; host bytes are
// buffered and presented show-ahead to the processor.
//   clk_i, rst_ni      clock, async active-low reset
//   serial_data_i      byte written by the processor
//   serial_wren_i      processor write strobe
//   serial_rden_i      processor read/pop strobe
//   serial_data_o      RX head byte (0 when RX buffer empty)
//   serial_valid_o     serial_data_o holds a valid byte
//   serial_ready_o     TX buffer can accept a byte
//   uart_txd_o         UART line, idle high
//   host_rx_data_i     inbound byte from host
//   host_rx_valid_i    host byte valid
//   host_rx_ready_o    RX buffer can accept a byte
//   tx_overflow_o      sticky: write attempted while TX buffer full
//   rx_underflow_o     sticky: read attempted while RX buffer empty
//
// TX FSM states:
//   state    | meaning
//   TX_IDLE  | line high, waiting for a buffered byte
//   TX_START | start bit (low)
//   TX_DATA  | 8 data bits, LSB first
//   TX_STOP  | stop bit (high); chains straight into next start if data waits
module serial_console_bridge
  import serial_console_bridge_pkg::*;
#(
  parameter int FIFO_DEPTH   = 16,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] serial_data_i,
  input  logic       serial_wren_i,
  input  logic       serial_rden_i,
  output logic [7:0] serial_data_o,
  output logic       serial_valid_o,
  output logic       serial_ready_o,
  output logic       uart_txd_o,
  input  logic [7:0] host_rx_data_i,
  input  logic       host_rx_valid_i,
  output logic       host_rx_ready_o,
  output logic       tx_overflow_o,
  output logic       rx_underflow_o
);

  localparam int                BAUD_W      = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);
  localparam int                BIT_W       = $clog2(UART_DATA_BITS);
  localparam logic [BIT_W-1:0]  BIT_LAST    = BIT_W'(UART_DATA_BITS - 1);

  tx_state_e                   state_q, state_d;
  logic [BAUD_W-1:0]           baud_q, baud_d;
  logic [BIT_W-1:0]            bit_q, bit_d;
  logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
  logic                        tx_overflow_q, tx_overflow_d;
  logic                        rx_underflow_q, rx_underflow_d;

  logic       tx_pop, tx_full, tx_empty, txd;
  logic [7:0] tx_head;
  logic       rx_full, rx_empty;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) tx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (serial_wren_i),
    .data_i  (serial_data_i),
    .pop_i   (tx_pop),
    .data_o  (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) rx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (host_rx_valid_i),
    .data_i  (host_rx_data_i),
    .pop_i   (serial_rden_i),
    .data_o  (serial_data_o),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  assign serial_ready_o  = !tx_full;
  assign serial_valid_o  = !rx_empty;
  assign host_rx_ready_o = !rx_full;
  assign tx_overflow_o   = tx_overflow_q;
  assign rx_underflow_o  = rx_underflow_q;

  // Line level is decoded from registered state so a reset forces it high
  // immediately rather than at the next edge.
  assign uart_txd_o = txd;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_pop  = 1'b0;
    txd     = LINE_IDLE;
    unique case (state_q)
      TX_IDLE: begin
        if (!tx_empty) begin
          tx_pop  = 1'b1;
          shift_d = tx_head;
          baud_d  = BAUD_RELOAD;
          state_d = TX_START;
        end
      end
      TX_START: begin
        txd = LINE_START;
        if (baud_q == '0) begin
          baud_d  = BAUD_RELOAD;
          bit_d   = '0;
          state_d = TX_DATA;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      TX_DATA: begin
        txd = shift_q[0];
        if (baud_q == '0) begin
          baud_d  = BAUD_RELOAD;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) state_d = TX_STOP;
          else                   bit_d   = bit_q + 1'b1;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      TX_STOP: begin
        txd = LINE_IDLE;
        if (baud_q == '0) begin
          // Back-to-back frames: skip IDLE when another byte is waiting.
          if (!tx_empty) begin
            tx_pop  = 1'b1;
            shift_d = tx_head;
            baud_d  = BAUD_RELOAD;
            state_d = TX_START;
          end else begin
            state_d = TX_IDLE;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_overflow_d  = tx_overflow_q  | (serial_wren_i && tx_full);
    rx_underflow_d = rx_underflow_q | (serial_rden_i && rx_empty);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= TX_IDLE;
      baud_q         <= '0;
      bit_q          <= '0;
      shift_q        <= '0;
      tx_overflow_q  <= 1'b0;
      rx_underflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      baud_q         <= baud_d;
      bit_q          <= bit_d;
      shift_q        <= shift_d;
      tx_overflow_q  <= tx_overflow_d;
      rx_underflow_q <= rx_underflow_d;
    end
  end

endmodule
